// File: rtl/sdram_bram_emulator_if.sv
// SDR SDRAM command/data bus between a controller (master) and the
// device emulator (slave). Signal names follow the SDRAM pin names.
interface sdram_bram_emulator_if;
    logic        sd_cke;
    logic        sd_cs_n;
    logic        sd_ras_n;
    logic        sd_cas_n;
    logic        sd_we_n;
    logic [1:0]  sd_bs;
    logic [12:0] sd_a;
    logic        sd_udqm;
    logic        sd_ldqm;
    logic [15:0] sd_dq_in;
    logic [15:0] sd_dq_out;
    logic        sd_dq_oe;

    modport master (
        output sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n,
        output sd_bs, sd_a, sd_udqm, sd_ldqm, sd_dq_in,
        input  sd_dq_out, sd_dq_oe
    );

    modport slave (
        input  sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n,
        input  sd_bs, sd_a, sd_udqm, sd_ldqm, sd_dq_in,
        output sd_dq_out, sd_dq_oe
    );
endinterface

// File: rtl/sdram_bram_emulator.sv
// SDR SDRAM device emulator: decodes sd_* commands, tracks open rows per
// bank, returns read data after the programmed CAS latency from an on-chip
// word array, and records the first protocol violation it sees.
module sdram_bram_emulator #(
    parameter int unsigned MEM_AW      = 12,
    parameter int unsigned COL_DEPTH   = 9,
    parameter int unsigned TREF_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sdram_bram_emulator_if.slave  sd,
    output logic                  err,
    output logic [2:0]            err_code,
    output logic [15:0]           refresh_cnt
);

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_e;

    localparam int unsigned TW    = $clog2(TREF_CYCLES + 1);
    localparam int unsigned DEPTH = 1 << MEM_AW;

    // command decode
    logic              cmd_valid;
    cmd_e              cmd;
    logic [8:0]        col;
    logic [23:0]       full_addr;
    logic [MEM_AW-1:0] idx;

    // bank state machine and device state
    bank_e             bank_q [4];
    bank_e             bank_d [4];
    logic [3:0][12:0]  row_q;
    logic [3:0][12:0]  row_d;
    logic              mode_set_q;
    logic              mode_set_d;
    logic [2:0]        cl_q;
    logic [2:0]        cl_d;
    logic [TW-1:0]     tref_q;
    logic [TW-1:0]     tref_d;
    logic [15:0]       refresh_cnt_d;
    logic              any_open;

    // violation tracking
    logic [6:1]        viol;
    logic [2:0]        viol_code;
    logic              err_d;
    logic [2:0]        err_code_d;

    // array access and read pipeline
    logic              rd_en;
    logic              wr_en;
    logic [15:0]       mem [DEPTH];
    logic [15:0]       rd_word;
    logic [15:0]       rd_masked;
    logic [1:0]        pipe_vld_q;
    logic [1:0]        pipe_vld_d;
    logic [1:0][15:0]  pipe_dat_q;
    logic [1:0][15:0]  pipe_dat_d;

    assign cmd_valid = sd.sd_cke & ~sd.sd_cs_n;
    assign cmd       = cmd_e'({sd.sd_ras_n, sd.sd_cas_n, sd.sd_we_n});

    // Word index: low MEM_AW bits of {bank, open row, column}
    always_comb begin
        col                 = '0;
        col[COL_DEPTH-1:0]  = sd.sd_a[COL_DEPTH-1:0];
        full_addr           = {sd.sd_bs, row_q[sd.sd_bs], col};
        idx                 = MEM_AW'(full_addr);
    end

    // Array read with per-lane masking captured at the READ edge
    always_comb begin
        rd_word   = mem[idx];
        rd_masked = {sd.sd_udqm ? 8'h00 : rd_word[15:8],
                     sd.sd_ldqm ? 8'h00 : rd_word[7:0]};
    end

    // Any bank currently open (AUTO REFRESH legality)
    always_comb begin
        any_open = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bank_q[i] == BANK_ACTIVE) any_open = 1'b1;
        end
    end

    // Next-state for banks, mode, refresh timer and violation detection
    always_comb begin
        bank_d        = bank_q;
        row_d         = row_q;
        mode_set_d    = mode_set_q;
        cl_d          = cl_q;
        tref_d        = tref_q;
        refresh_cnt_d = refresh_cnt;
        viol          = '0;
        rd_en         = 1'b0;
        wr_en         = 1'b0;

        // timer saturates at the limit so a late refresh stays flagged
        if (mode_set_q) begin
            if (tref_q == TW'(TREF_CYCLES)) viol[6] = 1'b1;
            else                            tref_d  = tref_q + 1'b1;
        end

        if (cmd_valid) begin
            unique case (cmd)
                CMD_ACT: begin
                    if (!mode_set_q) viol[1] = 1'b1;
                    if (bank_q[sd.sd_bs] == BANK_ACTIVE) viol[3] = 1'b1;
                    bank_d[sd.sd_bs] = BANK_ACTIVE;
                    row_d[sd.sd_bs]  = sd.sd_a;
                end
                CMD_RD, CMD_WR: begin
                    if (!mode_set_q) viol[1] = 1'b1;
                    if (bank_q[sd.sd_bs] == BANK_IDLE) begin
                        viol[2] = 1'b1;
                    end else begin
                        if (cmd == CMD_RD) rd_en = 1'b1;
                        else               wr_en = 1'b1;
                        if (sd.sd_a[10]) bank_d[sd.sd_bs] = BANK_IDLE;
                    end
                end
                CMD_PRE: begin
                    if (sd.sd_a[10]) begin
                        for (int unsigned i = 0; i < 4; i++) bank_d[i] = BANK_IDLE;
                    end else begin
                        bank_d[sd.sd_bs] = BANK_IDLE;
                    end
                end
                CMD_REF: begin
                    if (!mode_set_q) viol[1] = 1'b1;
                    if (any_open)    viol[4] = 1'b1;
                    refresh_cnt_d = refresh_cnt + 16'd1;
                    tref_d        = '0;
                end
                CMD_MRS: begin
                    mode_set_d = 1'b1;
                    tref_d     = '0;
                    if ((sd.sd_a[6:4] == 3'd2 || sd.sd_a[6:4] == 3'd3) &&
                        sd.sd_a[2:0] == 3'd0) begin
                        cl_d = sd.sd_a[6:4];
                    end else begin
                        viol[5] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Lowest-numbered violation of this cycle wins
    always_comb begin
        viol_code = '0;
        for (int unsigned i = 6; i >= 1; i--) begin
            if (viol[i]) viol_code = 3'(i);
        end
        err_d      = err;
        err_code_d = err_code;
        if (!err && viol_code != 3'd0) begin
            err_d      = 1'b1;
            err_code_d = viol_code;
        end
    end

    // Read pipeline: CL=2 enters the output-side stage, CL=3 one stage further back
    always_comb begin
        pipe_vld_d = {1'b0, pipe_vld_q[1]};
        pipe_dat_d = {16'h0000, pipe_dat_q[1]};
        if (rd_en) begin
            if (cl_q == 3'd3) begin
                pipe_vld_d[1] = 1'b1;
                pipe_dat_d[1] = rd_masked;
            end else begin
                pipe_vld_d[0] = 1'b1;
                pipe_dat_d[0] = rd_masked;
            end
        end
    end

    // State registers; everything freezes while sd_cke is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) bank_q[i] <= BANK_IDLE;
            row_q         <= '0;
            mode_set_q    <= 1'b0;
            cl_q          <= 3'd2;
            tref_q        <= '0;
            refresh_cnt   <= '0;
            err           <= 1'b0;
            err_code      <= '0;
            pipe_vld_q    <= '0;
            pipe_dat_q    <= '0;
            sd.sd_dq_oe   <= 1'b0;
            sd.sd_dq_out  <= '0;
        end else if (sd.sd_cke) begin
            bank_q        <= bank_d;
            row_q         <= row_d;
            mode_set_q    <= mode_set_d;
            cl_q          <= cl_d;
            tref_q        <= tref_d;
            refresh_cnt   <= refresh_cnt_d;
            err           <= err_d;
            err_code      <= err_code_d;
            pipe_vld_q    <= pipe_vld_d;
            pipe_dat_q    <= pipe_dat_d;
            sd.sd_dq_oe   <= pipe_vld_q[0];
            sd.sd_dq_out  <= pipe_vld_q[0] ? pipe_dat_q[0] : 16'h0000;
        end
    end

    // Word array, byte-lane write enables from DQM; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!sd.sd_udqm) mem[idx][15:8] <= sd.sd_dq_in[15:8];
            if (!sd.sd_ldqm) mem[idx][7:0]  <= sd.sd_dq_in[7:0];
        end
    end

endmodule

// File: tb/tb_sdram_bram_emulator.sv
// Self-checking bench for sdram_bram_emulator: directed protocol scenarios
// plus a randomized read/write stream checked against a word-array model.
module tb_sdram_bram_emulator;

    localparam int unsigned DEPTH = 4096;
    localparam logic [2:0] C_MRS = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_NOP = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        err;
    logic [2:0]  err_code;
    logic [15:0] refresh_cnt;
    int          checks;
    int          errors;

    typedef struct {
        int unsigned t;
        logic [15:0] d;
        logic [15:0] care;
    } rd_t;

    rd_t        rq [$];
    logic [7:0] mhi [int];
    logic [7:0] mlo [int];

    sdram_bram_emulator_if sd_if ();

    sdram_bram_emulator #(
        .MEM_AW      (12),
        .COL_DEPTH   (9),
        .TREF_CYCLES (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sd          (sd_if),
        .err         (err),
        .err_code    (err_code),
        .refresh_cnt (refresh_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_nop();
        sd_if.sd_cke   = 1'b1;
        sd_if.sd_cs_n  = 1'b0;
        {sd_if.sd_ras_n, sd_if.sd_cas_n, sd_if.sd_we_n} = C_NOP;
        sd_if.sd_bs    = 2'd0;
        sd_if.sd_a     = 13'd0;
        sd_if.sd_udqm  = 1'b0;
        sd_if.sd_ldqm  = 1'b0;
        sd_if.sd_dq_in = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_nop();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one command for the next rising edge, then return to NOP
    task automatic issue(input logic [2:0] c, input logic [1:0] b = 2'd0,
                         input logic [12:0] a = 13'd0, input logic u = 1'b0,
                         input logic l = 1'b0, input logic [15:0] d = 16'h0000);
        @(negedge clk);
        sd_if.sd_cke   = 1'b1;
        sd_if.sd_cs_n  = 1'b0;
        {sd_if.sd_ras_n, sd_if.sd_cas_n, sd_if.sd_we_n} = c;
        sd_if.sd_bs    = b;
        sd_if.sd_a     = a;
        sd_if.sd_udqm  = u;
        sd_if.sd_ldqm  = l;
        sd_if.sd_dq_in = d;
        @(posedge clk);
        #1 set_nop();
    endtask

    // READ then watch CL+1 cycles: data valid only after edge k+CL-1
    task automatic rd_chk(input string name, input logic [1:0] b, input logic [12:0] a,
                          input logic u, input logic l, input logic [15:0] exp,
                          input int cl);
        logic exp_oe;
        issue(C_RD, b, a, u, l);
        for (int j = 0; j <= cl; j++) begin
            @(negedge clk);
            exp_oe = (j == cl - 1);
            checks++;
            if (sd_if.sd_dq_oe !== exp_oe) begin
                errors++;
                $display("FAIL %s_oe[%0d]: got %b expected %b", name, j, sd_if.sd_dq_oe, exp_oe);
            end
            if (exp_oe) begin
                checks++;
                if (sd_if.sd_dq_out !== exp) begin
                    errors++;
                    $display("FAIL %s_data: got %h expected %h", name, sd_if.sd_dq_out, exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({sd_if.sd_dq_oe, sd_if.sd_dq_out, err, err_code, refresh_cnt} !== 37'd0) begin
            errors++;
            $display("FAIL reset: got oe=%b out=%h err=%b code=%0d ref=%0d expected all 0",
                     sd_if.sd_dq_oe, sd_if.sd_dq_out, err, err_code, refresh_cnt);
        end
    endtask

    task automatic test_basic_rw();
        issue(C_MRS, 2'd0, 13'h020);
        issue(C_ACT, 2'd1, 13'h123);
        issue(C_WR, 2'd1, 13'h045, 1'b0, 1'b0, 16'hBEEF);
        rd_chk("basic", 2'd1, 13'h045, 1'b0, 1'b0, 16'hBEEF, 2);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL basic_err: got %b expected 0", err);
        end
    endtask

    task automatic test_dqm_back_to_back();
        logic [15:0] exp_d [2];
        exp_d[0] = 16'hAB34;
        exp_d[1] = 16'h0034;
        issue(C_WR, 2'd1, 13'h045, 1'b0, 1'b0, 16'h1234);
        issue(C_WR, 2'd1, 13'h045, 1'b0, 1'b1, 16'hAB00);
        issue(C_RD, 2'd1, 13'h045, 1'b0, 1'b0);
        issue(C_RD, 2'd1, 13'h045, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if (sd_if.sd_dq_oe !== (j < 2)) begin
                errors++;
                $display("FAIL b2b_oe[%0d]: got %b expected %b", j, sd_if.sd_dq_oe, j < 2);
            end
            if (j < 2) begin
                checks++;
                if (sd_if.sd_dq_out !== exp_d[j]) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h expected %h", j, sd_if.sd_dq_out, exp_d[j]);
                end
            end
        end
    endtask

    task automatic test_cl3_illegal_mrs();
        issue(C_MRS, 2'd0, 13'h030);
        rd_chk("cl3", 2'd1, 13'h045, 1'b0, 1'b0, 16'hAB34, 3);
        issue(C_MRS, 2'd0, 13'h040);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd5) begin
            errors++;
            $display("FAIL bad_mrs: got err=%b code=%0d expected err=1 code=5", err, err_code);
        end
        rd_chk("cl_kept", 2'd1, 13'h045, 1'b0, 1'b1, 16'hAB00, 3);
    endtask

    task automatic test_idle_bank();
        do_reset();
        issue(C_MRS, 2'd0, 13'h020);
        issue(C_RD, 2'd2, 13'h010);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if (sd_if.sd_dq_oe !== 1'b0) begin
                errors++;
                $display("FAIL idle_oe[%0d]: got %b expected 0", j, sd_if.sd_dq_oe);
            end
        end
        checks++;
        if (err !== 1'b1 || err_code !== 3'd2) begin
            errors++;
            $display("FAIL idle_code: got err=%b code=%0d expected err=1 code=2", err, err_code);
        end
    endtask

    task automatic test_double_act();
        do_reset();
        issue(C_MRS, 2'd0, 13'h020);
        issue(C_ACT, 2'd0, 13'h001);
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL act_once: got err=%b expected 0", err);
        end
        issue(C_ACT, 2'd0, 13'h002);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd3) begin
            errors++;
            $display("FAIL act_twice: got err=%b code=%0d expected err=1 code=3", err, err_code);
        end
    endtask

    task automatic test_refresh();
        do_reset();
        issue(C_MRS, 2'd0, 13'h020);
        issue(C_REF);
        @(negedge clk);
        checks++;
        if (refresh_cnt !== 16'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL ref_ok: got cnt=%0d err=%b expected cnt=1 err=0", refresh_cnt, err);
        end
        repeat (55) @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL ref_early: got err=%b expected 0", err);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd6) begin
            errors++;
            $display("FAIL ref_late: got err=%b code=%0d expected err=1 code=6", err, err_code);
        end
        do_reset();
        issue(C_MRS, 2'd0, 13'h020);
        issue(C_ACT, 2'd3, 13'h0AA);
        issue(C_REF);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd4 || refresh_cnt !== 16'd1) begin
            errors++;
            $display("FAIL ref_open: got err=%b code=%0d cnt=%0d expected err=1 code=4 cnt=1",
                     err, err_code, refresh_cnt);
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        issue(C_MRS, 2'd0, 13'h030);
        issue(C_ACT, 2'd0, 13'h005);
        issue(C_RD, 2'd0, 13'h001);
        repeat (3) @(negedge clk);
        checks++;
        if (sd_if.sd_dq_oe !== 1'b1) begin
            errors++;
            $display("FAIL inflight_oe: got %b expected 1", sd_if.sd_dq_oe);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sd_if.sd_dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_oe: got %b expected 0", sd_if.sd_dq_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(C_RD, 2'd0, 13'h001);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd1 || sd_if.sd_dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL pre_mrs: got err=%b code=%0d oe=%b expected err=1 code=1 oe=0",
                     err, err_code, sd_if.sd_dq_oe);
        end
    endtask

    // Random reads/writes with DQM and CKE stalls against a word-array model;
    // expected read timing counted in clock-enabled edges only.
    task automatic test_random();
        int unsigned ecyc;
        int unsigned nref;
        int unsigned cl;
        int unsigned ph;
        int unsigned r;
        int          idx;
        logic [12:0] mrow [4];
        logic [2:0]  op;
        logic [1:0]  b;
        logic [8:0]  c;
        logic [12:0] a;
        logic        u;
        logic        l;
        logic        ck;
        logic        exp_oe;
        logic [15:0] d;
        rd_t         e;

        do_reset();
        mhi.delete();
        mlo.delete();
        rq.delete();
        cl = $urandom_range(2, 3);
        issue(C_MRS, 2'd0, 13'(cl << 4));
        for (int i = 0; i < 4; i++) begin
            mrow[i] = 13'($urandom);
            issue(C_ACT, 2'(i), mrow[i]);
        end
        ecyc = 0;
        nref = 0;
        for (int n = 0; n < 720; n++) begin
            @(negedge clk);
            while (rq.size() > 0 && rq[0].t < ecyc) void'(rq.pop_front());
            exp_oe = (rq.size() > 0 && rq[0].t == ecyc);
            checks++;
            if (sd_if.sd_dq_oe !== exp_oe) begin
                errors++;
                $display("FAIL rand_oe n=%0d: got %b expected %b", n, sd_if.sd_dq_oe, exp_oe);
            end
            if (exp_oe) begin
                checks++;
                if (((sd_if.sd_dq_out ^ rq[0].d) & rq[0].care) !== 16'h0000) begin
                    errors++;
                    $display("FAIL rand_data n=%0d: got %h expected %h (care %h)",
                             n, sd_if.sd_dq_out, rq[0].d, rq[0].care);
                end
            end

            ph = n % 24;
            ck = 1'b1;
            op = C_NOP;
            b  = 2'($urandom);
            c  = 9'($urandom);
            u  = ($urandom_range(0, 3) == 0);
            l  = ($urandom_range(0, 3) == 0);
            d  = 16'($urandom);
            a  = 13'(c);
            if (n >= 696) begin
                op = C_NOP;
            end else if (ph == 0) begin
                op = C_PRE;
                a  = 13'h0400;
            end else if (ph == 1) begin
                op = C_REF;
            end else if (ph < 6) begin
                op = C_ACT;
                b  = 2'(ph - 2);
                a  = 13'($urandom);
            end else begin
                ck = ($urandom_range(0, 7) != 0);
                r  = $urandom_range(0, 9);
                op = (r < 4) ? C_RD : ((r < 8) ? C_WR : C_NOP);
            end

            if (ck) begin
                idx = int'({b, mrow[b], c}) % DEPTH;
                if (op == C_ACT) mrow[b] = a;
                if (op == C_REF) nref++;
                if (op == C_WR) begin
                    if (!u) mhi[idx] = d[15:8];
                    if (!l) mlo[idx] = d[7:0];
                end
                if (op == C_RD) begin
                    e.t    = ecyc + cl;
                    e.d    = 16'h0000;
                    e.care = 16'hFFFF;
                    if (!u) begin
                        if (mhi.exists(idx)) e.d[15:8] = mhi[idx];
                        else                 e.care[15:8] = 8'h00;
                    end
                    if (!l) begin
                        if (mlo.exists(idx)) e.d[7:0] = mlo[idx];
                        else                 e.care[7:0] = 8'h00;
                    end
                    rq.push_back(e);
                end
                ecyc++;
            end

            sd_if.sd_cke   = ck;
            sd_if.sd_cs_n  = 1'b0;
            {sd_if.sd_ras_n, sd_if.sd_cas_n, sd_if.sd_we_n} = op;
            sd_if.sd_bs    = b;
            sd_if.sd_a     = a;
            sd_if.sd_udqm  = u;
            sd_if.sd_ldqm  = l;
            sd_if.sd_dq_in = d;
        end
        set_nop();
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || err_code !== 3'd0 || refresh_cnt !== 16'(nref)) begin
            errors++;
            $display("FAIL rand_end: got err=%b code=%0d cnt=%0d expected err=0 code=0 cnt=%0d",
                     err, err_code, refresh_cnt, nref);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_nop();
        test_reset();
        test_basic_rw();
        test_dqm_back_to_back();
        test_cl3_illegal_mrs();
        test_idle_bank();
        test_double_act();
        test_refresh();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
